ifetch_queue: RTL

Parametrised instruction-fetch unit with a prefetch queue. It decouples the F stage from the D-stage register. It generates requests to instruction memory with a hold-until-response handshake that tolerates `hit`/`abort`, buffers fetched words with their PC+4, and flushes and refetches on branch/jump redirect. Decode consumes entries under hazard-unit stall.

---
 rtl/ifetch_queue_pkg.sv | 15 +
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifetch_queue_fifo.sv | 55 +++++
 rtl/ifetch_queue.sv | 116 +++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_pkg: FSM state encoding, PC increment and queue entry layout shared
// by the instruction-fetch queue and its users.
package ifetch_pkg;

  typedef enum logic [1:0] {IFQ_IDLE, IFQ_REQ, IFQ_DISCARD} ifq_state_t;

  localparam int PC_STEP = 4;
  localparam int IFQ_W   = 32;

  typedef struct packed {
    logic [IFQ_W-1:0] instr;
    logic [IFQ_W-1:0] pc4;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: instruction-memory handshake, decode-side controls and the
// head-entry view of the fetch queue. master = fetch unit, slave = environment.
interface ifetch_queue_if #(parameter int W = 32);

  logic         instrreq;
  logic [W-1:0] instradr;
  logic [W-1:0] instrF;
  logic         hit;
  logic         abort;
  logic         stallD;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         validD;
  logic [W-1:0] instrD;
  logic [W-1:0] pc4D;
  logic [7:0]   pclow;

  modport master (
    output instrreq, instradr, validD, instrD, pc4D, pclow,
    input  instrF, hit, abort, stallD, redirect, redirect_pc
  );

  modport slave (
    input  instrreq, instradr, validD, instrD, pc4D, pclow,
    output instrF, hit, abort, stallD, redirect, redirect_pc
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: synchronous power-of-two FIFO with a flush input that wins over
// push/pop, an occupancy count and a combinational head view.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PTR_ONE;
      if (i_pop)  r_rd <= r_rd + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; only slots below the count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_wdata;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch FSM and PC logic in front of a prefetch FIFO feeding decode.
// Define IFQ_BYPASS_EN to forward a hit straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int           W        = 32,
  parameter int           DEPTH    = 4,
  parameter logic [W-1:0] RESET_PC = W'(32'h0000_0000)
) (
  input logic             clk,
  input logic             reset,
  ifetch_queue_if.master  bus
);

  import ifetch_pkg::*;

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_FREE = CW'(DEPTH-1);
  localparam logic [W-1:0]  STEP      = W'(PC_STEP);

  ifq_state_t     r_state;
  ifq_state_t     w_next_state;
  logic [W-1:0]   r_pc;
  logic [W-1:0]   r_adr;
  logic [W-1:0]   w_pc_next;
  logic [W-1:0]   w_pc4;
  logic [CW-1:0]  w_count;
  logic [2*W-1:0] w_head;
  logic           w_resp;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_bypass;

  assign w_pc4   = r_pc + STEP;
  assign w_resp  = bus.hit | bus.abort;
  assign w_empty = (w_count == '0);
  assign w_pop   = !w_empty && !bus.stallD && !bus.redirect;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && (r_state == IFQ_REQ) && bus.hit && !bus.redirect;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word that decode accepts this cycle never enters the queue.
  assign w_push = (r_state == IFQ_REQ) && bus.hit && !bus.redirect &&
                  !(w_bypass && !bus.stallD);

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    if (bus.redirect) w_pc_next = bus.redirect_pc;
    case (r_state)
      IFQ_IDLE: begin
        if (bus.redirect || (w_count < CNT_FULL)) w_next_state = IFQ_REQ;
      end
      IFQ_REQ: begin
        if (bus.redirect) begin
          w_next_state = w_resp ? IFQ_REQ : IFQ_DISCARD;
        end else if (bus.hit) begin
          w_pc_next    = w_pc4;
          w_next_state = (w_pop || (w_count < LAST_FREE)) ? IFQ_REQ : IFQ_IDLE;
        end
      end
      IFQ_DISCARD: begin
        if (w_resp) w_next_state = IFQ_REQ;
      end
      default: w_next_state = IFQ_IDLE;
    endcase
  end

  // r_adr freezes on the stale address while the abandoned request drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IFQ_IDLE;
      r_pc    <= RESET_PC;
      r_adr   <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_next_state != IFQ_DISCARD) r_adr <= w_pc_next;
    end
  end

  ifq_fifo #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.redirect),
    .i_wdata ({bus.instrF, w_pc4}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.instrreq = (r_state == IFQ_REQ) || (r_state == IFQ_DISCARD);
  assign bus.instradr = r_adr;
  assign bus.validD   = w_bypass || !w_empty;
  assign bus.pclow    = r_pc[9:2];

  always_comb begin
    bus.instrD = '0;
    bus.pc4D   = '0;
    if (w_bypass) begin
      bus.instrD = bus.instrF;
      bus.pc4D   = w_pc4;
    end else if (!w_empty) begin
      bus.instrD = w_head[2*W-1:W];
      bus.pc4D   = w_head[W-1:0];
    end
  end

endmodule
